// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the writeback arbiter
// Purpose: register-file geometry, the writeback request type and a
//          one-hot register decode helper used for the pending-write mask.
// Ports:   none (package).
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  // One register-file write: destination register and value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] r;
    r       = '0;
    r[addr] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - mult/div result queue for the writeback arbiter
// Purpose: DEPTH-entry FIFO of wb_req_t. Pointers are one bit wider than the
//          index so full and empty are distinguishable. Exposes every slot and
//          a per-slot valid vector so the owner can build a pending mask.
// Ports:   clock, ctrl_reset_n (async, active-low)
//          push/push_req   enqueue (ignored when full)
//          pop             dequeue (ignored when empty)
//          head            oldest entry
//          full/empty      occupancy flags
//          entries         raw storage, slot-indexed
//          entry_valid     bit i set when slot i holds a queued entry
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  ctrl_reset_n,
  input  logic                  push,
  input  wb_req_t               push_req,
  input  logic                  pop,
  output wb_req_t               head,
  output logic                  full,
  output logic                  empty,
  output wb_req_t [DEPTH-1:0]   entries,
  output logic    [DEPTH-1:0]   entry_valid
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] count;
  logic             do_push;
  logic             do_pop;
  wb_req_t          mem [DEPTH];

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                   (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[IDX_W-1:0]];

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Payload storage needs no reset: validity comes from the pointers alone.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[IDX_W-1:0]] <= push_req;
  end

  // A slot is live when its distance from the read index (mod DEPTH) is
  // below the current occupancy.
  always_comb begin
    entry_valid = '0;
    entries     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [IDX_W-1:0] ofs;
      ofs            = IDX_W'(i) - rd_ptr[IDX_W-1:0];
      entry_valid[i] = ({1'b0, ofs} < count);
      entries[i]     = mem[i];
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - register-file writeback arbiter (ALU vs mult/div)
// Purpose: drives the single register-file write port. ALU results win every
//          cycle; mult/div results queue in wb_fifo and drain when the ALU is
//          idle. A starvation counter pulses stall_alu so a waiting head drains.
//          Optional macro WB_BYPASS_EN lets a mult/div result skip an empty
//          queue when the ALU is idle.
// Ports:   clock, ctrl_reset_n (async, active-low)
//          alu_valid/alu_reg/alu_data       ALU result, no backpressure
//          md_valid/md_ready/md_reg/md_data mult/div result handshake
//          ctrl_writeEnable/ctrl_writeReg/data_writeReg  registered write port
//          stall_alu                        registered one-cycle ALU hold
//          pending_mask                     registers targeted by queued writes
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clock,
  input  logic                  ctrl_reset_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  md_valid,
  output logic                  md_ready,
  input  logic [REG_ADDR_W-1:0] md_reg,
  input  logic [DATA_W-1:0]     md_data,
  output logic                  ctrl_writeEnable,
  output logic [REG_ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0]     data_writeReg,
  output logic                  stall_alu,
  output logic [NUM_REGS-1:0]   pending_mask
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic                      alu_eff;
  logic                      md_keep;
  logic                      bypass;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  wb_req_t                   md_req;
  wb_req_t                   alu_req;
  wb_req_t                   fifo_head;
  wb_req_t [FIFO_DEPTH-1:0]  fifo_entries;
  logic    [FIFO_DEPTH-1:0]  fifo_entry_valid;
  logic                      win_valid;
  wb_req_t                   win_req;
  logic    [CNT_W-1:0]       starve_cnt;

  assign alu_req.reg_addr = alu_reg;
  assign alu_req.data     = alu_data;
  assign md_req.reg_addr  = md_reg;
  assign md_req.data      = md_data;

  // r0 writes are architecturally meaningless: ALU treats them as idle,
  // mult/div completes the handshake but drops the payload.
  assign alu_eff  = alu_valid && (alu_reg != '0);
  assign md_ready = !fifo_full;
  assign md_keep  = md_valid && md_ready && (md_reg != '0);

`ifdef WB_BYPASS_EN
  assign bypass = md_keep && fifo_empty && !alu_eff;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = md_keep && !bypass;
  assign fifo_pop  = !alu_eff && !fifo_empty;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .push         (fifo_push),
    .push_req     (md_req),
    .pop          (fifo_pop),
    .head         (fifo_head),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .entries      (fifo_entries),
    .entry_valid  (fifo_entry_valid)
  );

  // ALU wins even while stall_alu is up, so a misbehaving upstream never
  // loses data; the queued head simply waits another cycle.
  always_comb begin
    win_valid = 1'b1;
    win_req   = alu_req;
    if (alu_eff) begin
      win_req = alu_req;
    end else if (fifo_pop) begin
      win_req = fifo_head;
    end else if (bypass) begin
      win_req = md_req;
    end else begin
      win_valid = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else begin
      ctrl_writeEnable <= win_valid;
      if (win_valid) begin
        ctrl_writeReg <= win_req.reg_addr;
        data_writeReg <= win_req.data;
      end
    end
  end

  // starve_cnt counts completed waiting cycles of the current head. On the
  // STARVE_LIMIT-th such cycle it wraps to zero and stall_alu rises for the
  // next cycle, during which the ALU is idle and the head pops.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      starve_cnt <= '0;
      stall_alu  <= 1'b0;
    end else if (fifo_empty || fifo_pop) begin
      starve_cnt <= '0;
      stall_alu  <= 1'b0;
    end else if (starve_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
      starve_cnt <= '0;
      stall_alu  <= 1'b1;
    end else begin
      starve_cnt <= starve_cnt + CNT_W'(1);
      stall_alu  <= 1'b0;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_entry_valid[i]) pending_mask = pending_mask | reg_onehot(fifo_entries[i].reg_addr);
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb/tb_wb_write_arbiter.sv - scoreboard bench for wb_write_arbiter
module tb_wb_write_arbiter;
  import wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
`ifdef WB_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  logic        clock = 1'b0;
  logic        ctrl_reset_n;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_reg = '0;
  logic [31:0] alu_data = '0;
  logic        md_valid = 1'b0;
  logic        md_ready;
  logic [4:0]  md_reg = '0;
  logic [31:0] md_data = '0;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        stall_alu;
  logic [31:0] pending_mask;

  int vectors     = 0;
  int miscompares = 0;

  wb_req_t q[$];
  wb_req_t sb[$];
  int      m_cnt   = 0;
  bit      m_stall = 1'b0;
  bit      m_we    = 1'b0;

  wb_write_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .alu_valid        (alu_valid),
    .alu_reg          (alu_reg),
    .alu_data         (alu_data),
    .md_valid         (md_valid),
    .md_ready         (md_ready),
    .md_reg           (md_reg),
    .md_data          (md_data),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .stall_alu        (stall_alu),
    .pending_mask     (pending_mask)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    foreach (q[i]) m[q[i].reg_addr] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    q.delete();
    sb.delete();
    m_cnt   = 0;
    m_stall = 1'b0;
    m_we    = 1'b0;
  endtask

  // Behavioural model of one clock edge, fed from the bench's own inputs.
  task automatic model_edge();
    bit      emp, aeff, acc, byp, pp;
    wb_req_t w;
    emp  = (q.size() == 0);
    aeff = alu_valid && (alu_reg != 0);
    acc  = md_valid && (q.size() < DEPTH) && (md_reg != 0);
    byp  = 1'b0;
`ifdef WB_BYPASS_EN
    byp  = acc && emp && !aeff;
`endif
    pp   = !aeff && !emp;
    m_we = 1'b1;
    w    = '0;
    if (aeff) begin
      w.reg_addr = alu_reg; w.data = alu_data;
    end else if (pp) begin
      w = q[0];
    end else if (byp) begin
      w.reg_addr = md_reg; w.data = md_data;
    end else begin
      m_we = 1'b0;
    end
    if (m_we) sb.push_back(w);
    if (emp || pp) begin
      m_cnt = 0; m_stall = 1'b0;
    end else if (m_cnt + 1 == LIMIT) begin
      m_cnt = 0; m_stall = 1'b1;
    end else begin
      m_cnt++; m_stall = 1'b0;
    end
    if (pp) void'(q.pop_front());
    if (acc && !byp) begin
      w.reg_addr = md_reg; w.data = md_data;
      q.push_back(w);
    end
  endtask

  task automatic cmp_outputs();
    wb_req_t e;
    chk("md_ready", md_ready, q.size() < DEPTH);
    chk("pending_mask", pending_mask, model_mask());
    chk("stall_alu", stall_alu, m_stall);
    chk("write_enable", ctrl_writeEnable, m_we);
    if (ctrl_writeEnable) begin
      if (sb.size() == 0) begin
        chk("sb_depth", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("write_reg", ctrl_writeReg, e.reg_addr);
        chk("write_data", data_writeReg, e.data);
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    cmp_outputs();
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    md_valid  = 1'b0; md_reg  = '0; md_data  = '0;
  endtask

  initial begin
    int n;
    ctrl_reset_n = 1'b1;
    #1 ctrl_reset_n = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_we", ctrl_writeEnable, 0);
    chk("rst_reg", ctrl_writeReg, 0);
    chk("rst_data", data_writeReg, 0);
    chk("rst_stall", stall_alu, 0);
    chk("rst_mask", pending_mask, 0);
    ctrl_reset_n = 1'b1;
    model_reset();
    #1 chk("rst_md_ready", md_ready, 1);

    // ALU write r5
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    chk("alu_we", ctrl_writeEnable, 1);
    chk("alu_reg", ctrl_writeReg, 5);
    chk("alu_data", data_writeReg, 32'hDEADBEEF);
    idle_inputs();

    // ALU busy while five mult/div results are offered
    for (int k = 0; k < 5; k++) begin
      alu_valid = 1'b1; alu_reg = 5'(10 + k); alu_data = 32'h100 + k;
      md_valid  = 1'b1; md_reg  = 5'(k + 1);  md_data  = 32'hA0 + k;
      step();
      if (k == 3) begin
        chk("fill_ready", md_ready, 0);
        chk("fill_mask", pending_mask, 32'h0000001E);
      end
    end
    chk("fill_mask_held", pending_mask, 32'h0000001E);
    idle_inputs();
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("drain_reg", ctrl_writeReg, k);
    end
    step();
    chk("drain_empty_mask", pending_mask, 0);

    // r0 on both sources
    alu_valid = 1'b1; alu_reg = '0; alu_data = 32'h5555;
    md_valid  = 1'b1; md_reg  = '0; md_data  = 32'h6666;
    chk("zero_handshake", md_ready, 1);
    step();
    chk("zero_we", ctrl_writeEnable, 0);
    chk("zero_mask", pending_mask, 0);
    idle_inputs();

    // mult/div latency from an empty queue with idle ALU
    md_valid = 1'b1; md_reg = 5'd7; md_data = 32'h12;
    step();
    idle_inputs();
    n = 1;
    while (!ctrl_writeEnable && n < 6) begin
      step();
      n++;
    end
    chk("md_latency", n, EXP_LAT);
    chk("md_lat_reg", ctrl_writeReg, 7);
    chk("md_lat_data", data_writeReg, 32'h12);
    step();

    // starvation: one queued entry behind continuous ALU traffic
    alu_valid = 1'b1; alu_reg = 5'd20; alu_data = 32'h200;
    md_valid  = 1'b1; md_reg  = 5'd6;  md_data  = 32'h66;
    step();
    md_valid = 1'b0;
    n = 0;
    while (!stall_alu && n < 20) begin
      alu_valid = 1'b1; alu_reg = 5'd21; alu_data = $urandom;
      step();
      n++;
    end
    chk("starve_cycles", n, LIMIT);
    alu_valid = !m_stall;
    step();
    chk("starve_drain_we", ctrl_writeEnable, 1);
    chk("starve_drain_reg", ctrl_writeReg, 6);
    idle_inputs();
    step();

    // reset with three entries queued
    for (int k = 0; k < 3; k++) begin
      alu_valid = 1'b1; alu_reg = 5'd9; alu_data = 32'h900 + k;
      md_valid  = 1'b1; md_reg  = 5'(11 + k); md_data = 32'hB0 + k;
      step();
    end
    chk("pre_rst_mask", pending_mask, 32'h00003800);
    idle_inputs();
    #2 ctrl_reset_n = 1'b0;
    #1;
    chk("mid_rst_we", ctrl_writeEnable, 0);
    chk("mid_rst_reg", ctrl_writeReg, 0);
    chk("mid_rst_data", data_writeReg, 0);
    chk("mid_rst_mask", pending_mask, 0);
    chk("mid_rst_stall", stall_alu, 0);
    model_reset();
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    #1;
    chk("post_rst_ready", md_ready, 1);
    chk("post_rst_mask", pending_mask, 0);

    // random traffic; upstream honours stall_alu
    for (int c = 0; c < 400; c++) begin
      alu_valid = !m_stall && ($urandom_range(0, 3) != 0);
      alu_reg   = 5'($urandom_range(0, 31));
      alu_data  = $urandom;
      md_valid  = ($urandom_range(0, 2) != 0);
      md_reg    = 5'($urandom_range(0, 31));
      md_data   = $urandom;
      step();
    end
    idle_inputs();
    repeat (DEPTH + 4) step();
    chk("sb_left", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
